apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator: converts one-at-a-time request/response handshakes from an
//  internal agent (CPU load/store unit, debug port) into APB SETUP/ACCESS
//  transfers towards slaves such as apb_gpio. Handles wait states and PSLVERR,
//  and aborts transfers that exceed a PREADY timeout. One transfer in flight.
// PARAMETERS
//  APB_ADDR_WIDTH  12  PADDR / req_addr width
//  APB_DATA_WIDTH  16  PWDATA / PRDATA / req/rsp data width
//  TIMEOUT_CYCLES  16  max ACCESS cycles with PREADY low before abort; 0 = never
// PORTS
//  apb_pclk     in   1    clock; all logic on rising edge
//  apb_preset   in   1    reset, synchronous, active-high
//  req_valid    in   1    request present
//  req_ready    out  1    request accepted when req_valid & req_ready
//  req_write    in   1    1 = write, 0 = read
//  req_addr     in   AW   transfer address
//  req_wdata    in   DW   write data (ignored for reads)
//  rsp_valid    out  1    response present
//  rsp_ready    in   1    response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  DW   read data; 0 for writes and aborted transfers
//  rsp_err      out  1    PSLVERR seen or timeout
//  rsp_timeout  out  1    transfer aborted by timeout
//  apb_paddr    out  AW   APB address
//  apb_psel     out  1    APB select
//  apb_penable  out  1    APB enable
//  apb_pwrite   out  1    APB direction
//  apb_pwdata   out  DW   APB write data
//  apb_pready   in   1    slave ready; sampled only in ACCESS
//  apb_prdata   in   DW   slave read data; sampled with PREADY in ACCESS, reads only
//  apb_pslverr  in   1    slave error; sampled with PREADY in ACCESS
// BEHAVIOUR
//  - All outputs registered. On reset (any state): IDLE, req_ready=1, all other
//    outputs 0, wait counter 0; in-flight transfer and pending response dropped.
//  - FSM IDLE->SETUP->ACCESS->RESP->IDLE.
//  - IDLE: req_ready=1, psel=penable=0, paddr/pwrite/pwdata=0. On accept (edge N)
//    latch write/addr/wdata -> SETUP; req_ready=0 from N.
//  - SETUP (one cycle, N..N+1): psel=1, penable=0, paddr/pwrite/pwdata = latched.
//  - ACCESS: psel=1, penable=1, paddr/pwrite/pwdata unchanged. At each edge:
//    pready=1 -> capture prdata (reads) / 0 (writes) into rsp_rdata, pslverr into
//    rsp_err, rsp_timeout=0, psel=penable=0, -> RESP; pready=0 -> counter+1.
//  - Timeout: TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES with pready
//    still 0 -> psel=penable=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1 -> RESP.
//    pready=1 on the edge where the count would expire wins (normal completion).
//  - Minimum latency: accept at edge N, rsp_valid=1 from edge N+2 (zero waits);
//    each wait state adds one cycle.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_valid & rsp_ready at an edge ->
//    IDLE, rsp_valid=0, req_ready=1 next cycle (no request accepted in RESP).
//  - Back-to-back: at least one IDLE cycle (psel=0) between transfers.
//  - Counter width clog2(TIMEOUT_CYCLES+1); cleared on entering SETUP.
//  - req_* inputs ignored when req_ready=0; apb_p* inputs ignored outside ACCESS.
// TESTING
//  1 Write 0x1234 @200, pready=1 always -> psel 1 cyc SETUP, 1 cyc ACCESS
//    penable=1, pwrite=1, pwdata=0x1234; rsp_valid 2 cyc after accept, err=0.
//  2 Read @0x004, pready low 3 cyc then high, prdata=0xBEEF -> ACCESS 4 cyc,
//    paddr stable throughout, rsp_rdata=0xBEEF, rsp_err=0.
//  3 Write with pslverr=1 on ready edge -> rsp_err=1, rsp_timeout=0, rdata=0.
//  4 Read, pready stuck 0, TIMEOUT_CYCLES=16 -> psel drops after 16 ACCESS
//    wait cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//  5 rsp_ready held 0 for 5 cyc with req_valid high -> rsp stable, req_ready=0,
//    no new SETUP; after rsp_ready, next transfer starts after 1 IDLE cycle.
//  6 apb_preset mid-ACCESS -> next edge psel=penable=rsp_valid=0, req_ready=1;
//    then 10 random writes @200 into apb_gpio -> gpio_o equals each data value.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator bridging a valid/ready request/response agent onto APB.
// One transfer in flight; handles wait states, PSLVERR and PREADY timeout.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      apb_pclk,
  input  logic                      apb_preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  input  logic                      apb_pready,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
  input  logic                      apb_pslverr
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ?
    CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic accept;
  logic expire;

  assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign expire = TMO_EN && (cnt_q == CNT_LAST) && !apb_pready;

  // State and output registers with synchronous reset
  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state: IDLE -> SETUP -> ACCESS -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (apb_pready || expire) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered output values for the next cycle
  always_comb begin
    req_ready_d   = req_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          cnt_d       = '0;
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (apb_pready || expire) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          rsp_valid_d = 1'b1;
          if (apb_pready) begin
            rsp_rdata_d   = pwrite_q ? '0 : apb_prdata;
            rsp_err_d     = apb_pslverr;
            rsp_timeout_d = 1'b0;
          end else begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end else if (TMO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          req_ready_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready   = req_ready_q;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a one-register GPIO slave
// model at 0x200 used by the post-reset random write sequence.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [15:0] pwdata;
  logic        pready;
  logic [15:0] prdata;
  logic        pslverr;
  logic [15:0] gpio_o;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(12),
    .APB_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .apb_pclk   (clk),
    .apb_preset (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .apb_paddr  (paddr),
    .apb_psel   (psel),
    .apb_penable(penable),
    .apb_pwrite (pwrite),
    .apb_pwdata (pwdata),
    .apb_pready (pready),
    .apb_prdata (prdata),
    .apb_pslverr(pslverr)
  );

  // Minimal GPIO output register slave at address 0x200
  always @(posedge clk) begin
    if (rst) gpio_o <= '0;
    else if (psel && penable && pready && pwrite && paddr == 12'h200)
      gpio_o <= pwdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [11:0] a,
                       input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_wdata = 16'hDEAD;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout}
        !== 6'b100000) begin
      errs++;
      $display("FAIL reset_ctl got %b want 100000",
        {req_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout});
    end
    checks++;
    if ({paddr, pwdata, rsp_rdata, pwrite} !== 45'd0) begin
      errs++;
      $display("FAIL reset_data got %h want 0",
        {paddr, pwdata, rsp_rdata, pwrite});
    end
  endtask

  task automatic test_write();
    pready = 1'b1;
    issue(1'b1, 12'h200, 16'h1234);
    checks++;
    if ({psel, penable, pwrite, req_ready, rsp_valid} !== 5'b10100 ||
        paddr !== 12'h200 || pwdata !== 16'h1234) begin
      errs++;
      $display("FAIL wr_setup got ctl=%b a=%h d=%h want 10100 200 1234",
        {psel, penable, pwrite, req_ready, rsp_valid}, paddr, pwdata);
    end
    tick();
    checks++;
    if ({psel, penable, pwrite, rsp_valid} !== 4'b1110 ||
        pwdata !== 16'h1234) begin
      errs++;
      $display("FAIL wr_access got ctl=%b d=%h want 1110 1234",
        {psel, penable, pwrite, rsp_valid}, pwdata);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, psel} !== 4'b1000 ||
        rsp_rdata !== 16'h0) begin
      errs++;
      $display("FAIL wr_rsp got ctl=%b rd=%h want 1000 0",
        {rsp_valid, rsp_err, rsp_timeout, psel}, rsp_rdata);
    end
    finish_rsp();
    checks++;
    if ({rsp_valid, req_ready, psel} !== 3'b010) begin
      errs++;
      $display("FAIL wr_idle got %b want 010",
        {rsp_valid, req_ready, psel});
    end
  endtask

  task automatic test_read_wait();
    pready = 1'b0;
    prdata = 16'hBEEF;
    issue(1'b0, 12'h004, 16'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({psel, penable, pwrite, rsp_valid} !== 4'b1100 ||
          paddr !== 12'h004) begin
        errs++;
        $display("FAIL rd_access%0d got ctl=%b a=%h want 1100 004",
          i, {psel, penable, pwrite, rsp_valid}, paddr);
      end
      if (i == 3) pready = 1'b1;
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, psel} !== 4'b1000 ||
        rsp_rdata !== 16'hBEEF) begin
      errs++;
      $display("FAIL rd_rsp got ctl=%b rd=%h want 1000 beef",
        {rsp_valid, rsp_err, rsp_timeout, psel}, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_slverr();
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 16'h5555;
    issue(1'b1, 12'h010, 16'hA5A5);
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 ||
        rsp_rdata !== 16'h0) begin
      errs++;
      $display("FAIL slverr got ctl=%b rd=%h want 110 0",
        {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    pslverr = 1'b0;
    finish_rsp();
  endtask

  task automatic test_timeout();
    pready = 1'b0;
    prdata = 16'hAAAA;
    issue(1'b0, 12'h040, 16'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        errs++;
        $display("FAIL tmo_wait%0d got %b want 110",
          i, {psel, penable, rsp_valid});
      end
      tick();
    end
    checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111 ||
        rsp_rdata !== 16'h0) begin
      errs++;
      $display("FAIL tmo_rsp got ctl=%b rd=%h want 00111 0",
        {psel, penable, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_timeout_edge();
    pready = 1'b0;
    prdata = 16'h1357;
    issue(1'b0, 12'h044, 16'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) pready = 1'b1;
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 ||
        rsp_rdata !== 16'h1357) begin
      errs++;
      $display("FAIL tmo_edge got ctl=%b rd=%h want 100 1357",
        {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1;
    prdata = 16'h0F0F;
    issue(1'b0, 12'h008, 16'h0);
    tick();
    tick();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h00C;
    req_wdata = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, req_ready, psel, rsp_err} !== 4'b1000 ||
          rsp_rdata !== 16'h0F0F) begin
        errs++;
        $display("FAIL hold%0d got ctl=%b rd=%h want 1000 0f0f",
          i, {rsp_valid, req_ready, psel, rsp_err}, rsp_rdata);
      end
      tick();
    end
    finish_rsp();
    checks++;
    if ({rsp_valid, req_ready, psel} !== 3'b010) begin
      errs++;
      $display("FAIL b2b_idle got %b want 010",
        {rsp_valid, req_ready, psel});
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, req_ready} !== 4'b1010 ||
        paddr !== 12'h00C || pwdata !== 16'h7777) begin
      errs++;
      $display("FAIL b2b_setup got ctl=%b a=%h d=%h want 1010 00c 7777",
        {psel, penable, pwrite, req_ready}, paddr, pwdata);
    end
    tick();
    tick();
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    pready = 1'b0;
    issue(1'b1, 12'h200, 16'h4321);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL rst_mid got %b want 0001",
        {psel, penable, rsp_valid, req_ready});
    end
    pready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom_range(0, 65535));
      issue(1'b1, 12'h200, d);
      tick();
      tick();
      checks++;
      if (gpio_o !== d || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
        errs++;
        $display("FAIL gpio%0d got gpio=%h v=%b e=%b want %h 1 0",
          i, gpio_o, rsp_valid, rsp_err, d);
      end
      finish_rsp();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
